// File: rtl/proc_ctrl_pkg.sv
// Shared types and constants for the instruction-sequencing controller.
package proc_ctrl_pkg;

  // Controller states; the encodings are visible on the debug ports.
  typedef enum logic [3:0] {
    ST_INIT    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_HALT    = 4'd3,
    ST_SUB     = 4'd4,
    ST_ADD     = 4'd5,
    ST_STORE   = 4'd6,
    ST_LD_WAIT = 4'd7,
    ST_LD_WR   = 4'd8,
    ST_NOOP    = 4'd9,
    ST_LDI     = 4'd10,
    ST_JMP     = 4'd11,
    ST_JZ      = 4'd12
  } state_e;

  // Opcodes carried in IR[15:12]; 9..15 are illegal.
  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;
  localparam logic [3:0] OP_LDI   = 4'd6;
  localparam logic [3:0] OP_JMP   = 4'd7;
  localparam logic [3:0] OP_JZ    = 4'd8;

  // Register-file write-data select.
  localparam logic [1:0] RFS_ALU = 2'd0;
  localparam logic [1:0] RFS_MEM = 2'd1;
  localparam logic [1:0] RFS_IMM = 2'd2;

  // ALU function select.
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;

endpackage

// File: rtl/ld_wait_cnt.sv
// Loadable down-counter timing the data-memory read wait of a load.
module ld_wait_cnt #(
  parameter int W = 1
) (
  input  logic         Clk_i,
  input  logic         Reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  // Load on entry to the wait, count down while waiting, hold at zero.
  always_ff @(posedge Clk_i or posedge Reset_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (Reset_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Instruction-sequencing controller: fetch, decode and per-opcode datapath control.
module proc_ctrl_fsm
  import proc_ctrl_pkg::*;
#(
  parameter int DADDR_W   = 8,
  parameter int RF_ADDR_W = 4,
  parameter int PC_W      = 8,
  parameter int RD_LAT    = 1
) (
  input  logic                 Clk_i,
  input  logic                 Reset_i,
  input  logic [15:0]          IR_i,
  input  logic                 RF_Ra_zero_i,
  input  logic                 Resume_i,
  output logic                 PC_clr_o,
  output logic                 PC_up_o,
  output logic                 PC_ld_o,
  output logic [PC_W-1:0]      PC_val_o,
  output logic                 IR_ld_o,
  output logic [DADDR_W-1:0]   D_addr_o,
  output logic                 D_wr_o,
  output logic [1:0]           RF_s_o,
  output logic [RF_ADDR_W-1:0] RF_Ra_addr_o,
  output logic [RF_ADDR_W-1:0] RF_Rb_addr_o,
  output logic [RF_ADDR_W-1:0] RF_W_Addr_o,
  output logic                 RF_W_en_o,
  output logic [2:0]           ALU_s0_o,
  output logic                 Halted_o,
  output logic                 Err_o,
  output logic [3:0]           CurrentState_o,
  output logic [3:0]           NextState_o
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  state_e     state_q, state_d;
  logic       err_q;
  logic       err_set;
  logic       cnt_load, cnt_dec, cnt_done;
  logic [3:0] opcode;

  assign opcode = IR_i[15:12];

  // Wait counter for the memory read latency; loaded so the wait lasts RD_LAT cycles.
  ld_wait_cnt #(.W(CNT_W)) u_ld_wait_cnt (
    .Clk_i      (Clk_i),
    .Reset_i    (Reset_i),
    .load_i     (cnt_load),
    .load_val_i (CNT_W'(RD_LAT - 1)),
    .dec_i      (cnt_dec),
    .done_o     (cnt_done)
  );

  // Next-state selection, wait-counter control and illegal-opcode detection.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      ST_INIT:   state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_NOOP:  state_d = ST_NOOP;
          OP_STORE: state_d = ST_STORE;
          OP_LOAD: begin
            state_d  = ST_LD_WAIT;
            cnt_load = 1'b1;
          end
          OP_ADD:   state_d = ST_ADD;
          OP_SUB:   state_d = ST_SUB;
          OP_HALT:  state_d = ST_HALT;
          OP_LDI:   state_d = ST_LDI;
          OP_JMP:   state_d = ST_JMP;
          OP_JZ:    state_d = ST_JZ;
          default: begin
            state_d = ST_HALT;
            err_set = 1'b1;
          end
        endcase
      end
      ST_HALT: begin
        if (Resume_i && !err_q) state_d = ST_FETCH;
      end
      ST_LD_WAIT: begin
        if (cnt_done) state_d = ST_LD_WR;
        else          cnt_dec = 1'b1;
      end
      ST_LD_WR, ST_ADD, ST_SUB, ST_STORE, ST_NOOP, ST_LDI, ST_JMP, ST_JZ:
        state_d = ST_FETCH;
      default:   state_d = ST_INIT;
    endcase
  end

  // State register and sticky error flag; only reset clears the error.
  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q <= ST_INIT;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (err_set) err_q <= 1'b1;
    end
  end

  // Moore datapath controls decoded from the current state and IR fields.
  always_comb begin
    PC_clr_o     = 1'b0;
    PC_up_o      = 1'b0;
    PC_ld_o      = 1'b0;
    PC_val_o     = '0;
    IR_ld_o      = 1'b0;
    D_addr_o     = '0;
    D_wr_o       = 1'b0;
    RF_s_o       = RFS_ALU;
    RF_Ra_addr_o = '0;
    RF_Rb_addr_o = '0;
    RF_W_Addr_o  = '0;
    RF_W_en_o    = 1'b0;
    ALU_s0_o     = '0;
    Halted_o     = 1'b0;
    case (state_q)
      ST_INIT:  PC_clr_o = 1'b1;
      ST_FETCH: begin
        IR_ld_o = 1'b1;
        PC_up_o = 1'b1;
      end
      ST_HALT:  Halted_o = 1'b1;
      ST_ADD, ST_SUB: begin
        RF_Ra_addr_o = IR_i[8 +: RF_ADDR_W];
        RF_Rb_addr_o = IR_i[4 +: RF_ADDR_W];
        RF_W_Addr_o  = IR_i[0 +: RF_ADDR_W];
        RF_W_en_o    = 1'b1;
        RF_s_o       = RFS_ALU;
        ALU_s0_o     = (state_q == ST_ADD) ? ALU_ADD : ALU_SUB;
      end
      ST_STORE: begin
        RF_Ra_addr_o = IR_i[8 +: RF_ADDR_W];
        D_addr_o     = IR_i[0 +: DADDR_W];
        D_wr_o       = 1'b1;
      end
      ST_LD_WAIT, ST_LD_WR: begin
        D_addr_o    = IR_i[4 +: DADDR_W];
        RF_s_o      = RFS_MEM;
        RF_W_Addr_o = IR_i[0 +: RF_ADDR_W];
        RF_W_en_o   = (state_q == ST_LD_WR);
      end
      ST_LDI: begin
        RF_s_o      = RFS_IMM;
        RF_W_Addr_o = IR_i[0 +: RF_ADDR_W];
        RF_W_en_o   = 1'b1;
      end
      ST_JMP: begin
        PC_ld_o  = 1'b1;
        PC_val_o = IR_i[0 +: PC_W];
      end
      ST_JZ: begin
        RF_Ra_addr_o = IR_i[8 +: RF_ADDR_W];
        PC_val_o     = IR_i[0 +: PC_W];
        PC_ld_o      = RF_Ra_zero_i;
      end
      default: ;
    endcase
  end

  assign Err_o          = err_q;
  assign CurrentState_o = state_q;
  assign NextState_o    = state_d;

endmodule

// File: doc/proc_ctrl_fsm.md
# proc_ctrl_fsm

Parametrised instruction-sequencing controller for the 16-bit processor; second-generation control unit. Fetches and decodes 16-bit instructions and drives PC, instruction register, data memory, register file and ALU control lines. Adds configurable data-memory read latency, immediate load, unconditional and conditional jumps, a resumable halt, and a sticky illegal-opcode error. Sits between the instruction register and the datapath, replacing the fixed-latency controller.

## Interface
- DADDR_W, 8, data-memory address width (1..8, taken from low bits of IR address fields)
- RF_ADDR_W, 4, register-file address width (1..4)
- PC_W, 8, program-counter width (1..8, jump target = IR[PC_W-1:0])
- RD_LAT, 1, data-memory read wait cycles before register write (1..15)
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- IR  in  16  instruction register contents
- RF_Ra_zero  in  1  datapath flag, RF A-port data == 0 (combinational, same cycle)
- Resume  in  1  leave HALT (ignored when Err=1)
- PC_clr, PC_up, PC_ld  out  1 each  PC clear / increment / load
- PC_val  out  PC_W  PC load value
- IR_ld  out  1  instruction load
- D_addr  out  DADDR_W  data-memory address
- D_wr  out  1  data-memory write enable
- RF_s  out  2  RF write-data select: 0 ALU, 1 memory, 2 immediate IR[11:4]
- RF_Ra_addr, RF_Rb_addr, RF_W_Addr  out  RF_ADDR_W each  RF addresses
- RF_W_en  out  1  RF write enable
- ALU_s0  out  3  ALU function (1 add, 2 sub, else 0)
- Halted  out  1  high in HALT
- Err  out  1  sticky illegal-opcode flag
- CurrentState, NextState  out  4  debug state encodings

## Operation
- States (encoding): INIT 0, FETCH 1, DECODE 2, HALT 3, SUB 4, ADD 5, STORE 6, LD_WAIT 7, LD_WR 8, NOOP 9, LDI 10, JMP 11, JZ 12.
- Every output defaults to 0 each cycle; each state asserts only what is listed.
- INIT: PC_clr=1 -> FETCH. FETCH: IR_ld=1, PC_up=1 -> DECODE.
- DECODE on IR[15:12]: 0 NOOP, 1 STORE, 2 LD_WAIT, 3 ADD, 4 SUB, 5 HALT, 6 LDI, 7 JMP, 8 JZ; 9..15 -> HALT and set Err.
- ADD/SUB: Ra=IR[11:8], Rb=IR[7:4], W_Addr=IR[3:0], RF_W_en=1, RF_s=0, ALU_s0=1/2 -> FETCH.
- STORE: Ra=IR[11:8], D_addr=IR[7:0], D_wr=1 -> FETCH.
- LD_WAIT: D_addr=IR[11:4], RF_s=1, W_Addr=IR[3:0]; stays RD_LAT cycles (wait counter), then LD_WR. LD_WR: same plus RF_W_en=1 -> FETCH.
- LDI: RF_s=2, W_Addr=IR[3:0], RF_W_en=1 -> FETCH.
- JMP: PC_ld=1, PC_val=IR[PC_W-1:0] -> FETCH.
- JZ: Ra=IR[11:8], PC_val=IR[PC_W-1:0]; PC_ld=RF_Ra_zero -> FETCH.
- HALT: Halted=1; Resume=1 and Err=0 -> FETCH, else stay.
- Address fields truncate to low bits of each field (e.g. W_Addr=IR[RF_ADDR_W-1:0]).
- Unused encodings 13..15 -> INIT.

## Timing
- Moore outputs: combinational from CurrentState and IR; state registers update on rising Clk.
- Reset: asynchronous, CurrentState=INIT, wait counter=0, Err=0; outputs therefore PC_clr=1, all others 0.
- Instruction cycles: NOOP/ADD/SUB/STORE/LDI/JMP/JZ 3 clocks; load 3+RD_LAT clocks.
- Err sets on the DECODE->HALT edge; clears only by Reset.
- Reset mid-load (any LD_* cycle): no RF_W_en issued, counter cleared.
- Resume during any state other than HALT: ignored.

## Structure
- Package proc_ctrl_pkg: state enum (4-bit), opcode localparams, RF_s and ALU_s0 select constants.
- Sub-module ld_wait_cnt: loadable down-counter, width $clog2(RD_LAT+1), done flag.

## Test plan
- Reset asserted mid-clock, IR=0 -> CurrentState=0 immediately, PC_clr=1; after release INIT->FETCH->DECODE->NOOP->FETCH.
- RD_LAT=3, IR=16'h20_0A -> LD_WAIT exactly 3 cycles with D_addr=8'h00, RF_s=1; LD_WR one cycle, RF_W_en=1, W_Addr=4'hA.
- IR=16'h334D -> ADD: Ra=3, Rb=4, W_Addr=13, ALU_s0=1, RF_W_en=1; IR=16'h4431 -> SUB, ALU_s0=2.
- IR=16'h8012 with RF_Ra_zero=1 -> JZ PC_ld=1, PC_val=8'h12; repeat with RF_Ra_zero=0 -> PC_ld=0.
- IR=16'h5000 -> HALT, Halted=1 for 10 cycles; Resume pulse -> FETCH next edge, Err=0.
- IR=16'hF000 -> HALT, Err=1; Resume ignored for 10 cycles; Reset clears Err.
